// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame state encodings, line levels and parity helper
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD = 1'b1;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   function automatic logic calc_parity(input logic [8:0] data, input logic typ);
      return (^data) ^ (typ == PAR_ODD);
   endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte handshake and serial line between TX data source and transmitter
interface uart_tx_frame_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] p_data;
   logic data_valid;
   logic par_en;
   logic par_typ;
   logic tx_out;
   logic busy;
   modport master(output p_data, data_valid, par_en, par_typ, input tx_out, busy);
   modport slave(input p_data, data_valid, par_en, par_typ, output tx_out, busy);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: latched data word and bit counter, presents the next bit to put on the line
module uart_tx_serializer #(parameter int DATA_WIDTH = 8) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  run,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  ser_bit,
   output logic                  ser_done
);
   localparam int CW = $clog2(DATA_WIDTH);
   logic [CW-1:0] cnt, cnt_n;
   // next bit is data[0] when leaving START, otherwise the bit after the one on the line
   always_comb begin
      cnt_n = cnt + 1'b1;
      ser_bit = run ? data[cnt_n] : data[0];
      ser_done = run && (cnt == CW'(DATA_WIDTH - 1));
   end
   // load restarts the count at bit 0, run steps one bit per cycle
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         data <= '0;
         cnt <= '0;
      end else if (load) begin
         data <= din;
         cnt <= '0;
      end else if (run)
         cnt <= cnt_n;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART frame transmitter; define UART_TX_TWO_STOP_EN for two stop bits
module uart_tx_frame
   import uart_pkg::*;
#(parameter int DATA_WIDTH = 8) (
   input logic clk,
   input logic rst,
   uart_tx_frame_if.slave bus
);
   uart_state_e state, nxt;
   logic [DATA_WIDTH-1:0] ser_data;
   logic ser_bit, ser_done, par_bit, accept;
   logic tx_q, busy_q, tx_d, busy_d, par_en_q, par_typ_q;
`ifdef UART_TX_TWO_STOP_EN
   logic stop_ph;
   // second stop cycle is the one following a STOP cycle
   always_ff @(posedge clk or negedge rst)
      if (!rst) stop_ph <= 1'b0;
      else stop_ph <= (state == STOP);
`endif
   assign accept = bus.data_valid & ~busy_q;
   assign par_bit = calc_parity(9'(ser_data), par_typ_q);
   assign bus.tx_out = tx_q;
   assign bus.busy = busy_q;
   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .clk(clk), .rst(rst), .load(accept), .run(state == DATA),
      .din(bus.p_data), .data(ser_data), .ser_bit(ser_bit), .ser_done(ser_done)
   );
   // next state, and line/busy values decoded from it so both outputs are registered
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:   nxt = accept ? START : IDLE;
         START:  nxt = DATA;
         DATA:   nxt = ser_done ? (par_en_q ? PARITY : STOP) : DATA;
         PARITY: nxt = STOP;
`ifdef UART_TX_TWO_STOP_EN
         STOP:   nxt = !stop_ph ? STOP : accept ? START : IDLE;
`else
         STOP:   nxt = accept ? START : IDLE;
`endif
         default: nxt = IDLE;
      endcase
      tx_d = (nxt == START) ? START_BIT : (nxt == DATA) ? ser_bit : (nxt == PARITY) ? par_bit : LINE_IDLE;
`ifdef UART_TX_TWO_STOP_EN
      busy_d = (nxt inside {START, DATA, PARITY}) || (nxt == STOP && state != STOP);
`else
      busy_d = nxt inside {START, DATA, PARITY};
`endif
   end
   // state and output registers; frame options are captured with the data word
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         tx_q <= LINE_IDLE;
         busy_q <= 1'b0;
         par_en_q <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         state <= nxt;
         tx_q <= tx_d;
         busy_q <= busy_d;
         if (accept) begin
            par_en_q <= bus.par_en;
            par_typ_q <= bus.par_typ;
         end
      end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame; expected line/busy per cycle queued at stimulus time
module tb_uart_tx_frame;
`ifdef UART_TX_TWO_STOP_EN
   localparam int FLEN = 11;
`else
   localparam int FLEN = 10;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int failures = 0;
   int entry = 0;
   logic [1:0] sb[$];
   logic [1:0] exp_e;
   uart_tx_frame_if #(.DATA_WIDTH(8)) bus();
   uart_tx_frame #(.DATA_WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic push_idle(input int n);
      repeat (n) sb.push_back(2'b10);
   endtask
   task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
      logic p;
      p = pt;
      sb.push_back(2'b01);
      for (int i = 0; i < 8; i++) begin
         sb.push_back({d[i], 1'b1});
         p = p ^ d[i];
      end
      if (pe) sb.push_back({p, 1'b1});
`ifdef UART_TX_TWO_STOP_EN
      sb.push_back(2'b11);
`endif
      sb.push_back(2'b10);
   endtask
   task automatic send(input logic [7:0] d, input logic pe, input logic pt);
      bus.p_data = d;
      bus.par_en = pe;
      bus.par_typ = pt;
      bus.data_valid = 1'b1;
      push_frame(d, pe, pt);
      @(negedge clk);
      #1;
      bus.data_valid = 1'b0;
      bus.p_data = ~d;
      bus.par_en = ~pe;
      bus.par_typ = ~pt;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("drain", sb.size(), 0);
   endtask
   initial forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
         exp_e = sb.pop_front();
         check($sformatf("tx#%0d", entry), bus.tx_out, exp_e[1]);
         check($sformatf("busy#%0d", entry), bus.busy, exp_e[0]);
         entry++;
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      bus.p_data = '0;
      bus.data_valid = 1'b0;
      bus.par_en = 1'b0;
      bus.par_typ = 1'b0;
      #12;
      check("rst_tx", bus.tx_out, 1);
      check("rst_busy", bus.busy, 0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      push_idle(20);
      drain();
      send(8'hA5, 1'b1, 1'b0);
      push_idle(2);
      drain();
      send(8'hA5, 1'b1, 1'b1);
      push_idle(2);
      drain();
      send(8'h00, 1'b0, 1'b0);
      push_idle(2);
      drain();
      bus.p_data = 8'h55;
      bus.par_en = 1'b0;
      bus.par_typ = 1'b0;
      bus.data_valid = 1'b1;
      push_frame(8'h55, 1'b0, 1'b0);
      push_frame(8'h0F, 1'b0, 1'b0);
      push_idle(2);
      @(negedge clk);
      #1;
      bus.p_data = 8'h0F;
      repeat (FLEN) @(negedge clk);
      #1;
      bus.data_valid = 1'b0;
      bus.p_data = 8'hC3;
      drain();
      bus.p_data = 8'hFF;
      bus.par_en = 1'b0;
      bus.data_valid = 1'b1;
      sb.push_back(2'b01);
      repeat (4) sb.push_back(2'b11);
      @(negedge clk);
      #1;
      bus.data_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_tx", bus.tx_out, 1);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_sb", sb.size(), 0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      push_idle(3);
      drain();
      send(8'h81, 1'b1, 1'b1);
      push_idle(2);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
